unified_mem_arbiter: RTL
========================

Name: unified_mem_arbiter

Overview:
- Shares one single-ported external memory between the IF-stage instruction fetch and the MEM-stage load/store of the 5-stage MIPS pipeline.
- Sequences the accesses over a req/ack handshake and generates the global pipeline stall.
- Registers returned fetch and load data and holds them stable until the pipeline advances.
- Data accesses take priority over fetches, because the MEM-stage instruction is older.

Parameters:
- ADDR_WIDTH, 32, byte address width on all address ports.
- DATA_WIDTH, 32, word width.
- TIMEOUT_CYCLES, 255, cycles to wait for mem_ack before aborting an access; 0 disables the timeout.
- TO_WIDTH, 8, timeout counter width; must satisfy 2^TO_WIDTH > TIMEOUT_CYCLES.

Ports:
- clk  in  1  single clock; all state updates on its rising edge.
- reset  in  1  synchronous, active-high reset.
- if_req  in  1  fetch requested this pipeline cycle; tied high in normal operation.
- if_addr  in  ADDR_WIDTH  fetch address (PC).
- if_rdata  out  DATA_WIDTH  registered instruction word.
- dm_read  in  1  MEM-stage load.
- dm_write  in  1  MEM-stage store.
- dm_addr  in  ADDR_WIDTH  load/store address (EX/MEM ALU result).
- dm_wdata  in  DATA_WIDTH  store data.
- dm_rdata  out  DATA_WIDTH  registered load data.
- mem_req  out  1  external request, registered.
- mem_we  out  1  external write enable, registered.
- mem_addr  out  ADDR_WIDTH  external word address, registered; bits [1:0] forced to 0.
- mem_wdata  out  DATA_WIDTH  external write data, registered.
- mem_rdata  in  DATA_WIDTH  external read data, valid when mem_ack=1.
- mem_ack  in  1  external completion strobe.
- pipe_stall  out  1  combinational; freezes PC, IF/ID, ID/EX, EX/MEM and MEM/WB while high.
- bus_err  out  1  sticky error flag (timeout or misaligned data access).

Behaviour:
- Reset, applied on the clock edge where reset=1, overrides everything including an in-flight access:
  - state=IDLE; mem_req, mem_we, mem_addr, mem_wdata = 0.
  - if_rdata, dm_rdata = 0; bus_err = 0.
  - Done flags d_done, i_done = 0; timeout counter = 0.
  - A mem_ack arriving after reset is ignored.
- Derived signals:
  - dm_req = dm_read | dm_write.
  - pipe_stall = (dm_req & ~d_done) | (if_req & ~i_done).
- States: IDLE, DATA, FETCH.
- IDLE:
  - If dm_req & ~d_done: go to DATA. Latch mem_addr={dm_addr[ADDR_WIDTH-1:2],2'b00}, mem_we=dm_write, mem_wdata=dm_wdata, and set mem_req=1.
  - Else if if_req & ~i_done: go to FETCH. Latch mem_addr from if_addr (low bits zeroed), mem_we=0, mem_req=1.
  - Else stay in IDLE with mem_req=0.
  - mem_ack is ignored in IDLE.
- DATA/FETCH:
  - mem_req, mem_we, mem_addr and mem_wdata are held stable.
  - The counter increments every cycle that mem_ack=0.
  - On mem_ack=1 in DATA: dm_rdata<=mem_rdata (load only; a store leaves dm_rdata unchanged), d_done<=1, mem_req<=0, go to IDLE.
  - On mem_ack=1 in FETCH: if_rdata<=mem_rdata, i_done<=1, mem_req<=0, go to IDLE.
  - Timeout: when TIMEOUT_CYCLES≠0 and the counter reaches TIMEOUT_CYCLES without an ack, the access completes as if acked with rdata=0 (a fetch therefore returns a NOP), and bus_err<=1. The counter clears on leaving the state.
- Done flags: on any edge where pipe_stall=0 (the pipeline advances), d_done and i_done both clear.
- Latency: request first visible in cycle N → mem_req=1 in N+1. If ack arrives in cycle M, the done flag is set at the end of M and pipe_stall drops in M+1 (if nothing else is pending). Minimum stall with a zero-wait memory is 2 cycles per access.
- Simultaneous load/store and fetch are serialised as DATA then FETCH; one back-to-back IDLE cycle between them is permitted.
- Misaligned data access (dm_req & dm_addr[1:0]≠0) sets bus_err when entering DATA; the access is still performed at the word address.
- dm_read=dm_write=1 is treated as a store.
- Request inputs are sampled only in IDLE; changes during DATA/FETCH have no effect on the in-flight access.

Test Plan:
1. Reset, then if_req=1, if_addr=0x0000_0040, memory acks 3 cycles after mem_req with 0x2008_0005 → mem_addr=0x40, mem_we=0. if_rdata=0x2008_0005 on the cycle pipe_stall falls. pipe_stall is high for 5 cycles.
2. dm_read=1 at 0x100 together with if_req at 0x44, zero-wait memory returning 0xDEAD_BEEF then 0x0000_0000 → first mem_addr is 0x100, second is 0x44. dm_rdata=0xDEAD_BEEF, if_rdata=0. pipe_stall is released only after both accesses complete.
3. dm_write=1, dm_addr=0x200, dm_wdata=0x1234_5678 → mem_we=1, mem_wdata=0x1234_5678 held stable until ack. dm_rdata is unchanged. No duplicate write occurs while pipe_stall stays high.
4. TIMEOUT_CYCLES=4, fetch at 0x80 with mem_ack never asserted → completes after 4 waiting cycles with if_rdata=0 and bus_err=1. bus_err stays high until reset.
5. Assert reset in the second cycle of a DATA access → next cycle shows mem_req=0, state IDLE, pipe_stall reflects only current requests. A late mem_ack does not update dm_rdata.
6. mem_ack pulsed while IDLE, then dm_read at address 0x102 → the stray ack is ignored. Access is made to mem_addr=0x100 and bus_err=1.

Source files
------------

// File: rtl/unified_mem_arbiter.sv
// Arbitrates one single-ported memory between instruction fetch and load/store,
// data first; holds the pipeline with pipe_stall until each pending access completes.
module unified_mem_arbiter #(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 255,
  parameter int TO_WIDTH       = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  if_req,
  input  logic [ADDR_WIDTH-1:0] if_addr,
  output logic [DATA_WIDTH-1:0] if_rdata,
  input  logic                  dm_read,
  input  logic                  dm_write,
  input  logic [ADDR_WIDTH-1:0] dm_addr,
  input  logic [DATA_WIDTH-1:0] dm_wdata,
  output logic [DATA_WIDTH-1:0] dm_rdata,
  output logic                  mem_req,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  input  logic                  mem_ack,
  output logic                  pipe_stall,
  output logic                  bus_err
);

  typedef enum logic [1:0] {IDLE, DATA, FETCH} state_t;

  localparam logic [ADDR_WIDTH-1:0] WORD_MASK = ~ADDR_WIDTH'(3);

  state_t                state_q, state_d;
  logic                  mem_req_q, mem_req_d;
  logic                  mem_we_q, mem_we_d;
  logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_WIDTH-1:0] mem_wdata_q, mem_wdata_d;
  logic [DATA_WIDTH-1:0] if_rdata_q, if_rdata_d;
  logic [DATA_WIDTH-1:0] dm_rdata_q, dm_rdata_d;
  logic                  bus_err_q, bus_err_d;
  logic                  d_done_q, d_done_d;
  logic                  i_done_q, i_done_d;
  logic [TO_WIDTH-1:0]   to_cnt_q, to_cnt_d;

  logic                  dm_req;
  logic                  timeout;
  logic [DATA_WIDTH-1:0] rdata_v;

  assign dm_req     = dm_read | dm_write;
  assign pipe_stall = (dm_req & ~d_done_q) | (if_req & ~i_done_q);
  assign timeout    = (TIMEOUT_CYCLES != 0) && (to_cnt_q == TO_WIDTH'(TIMEOUT_CYCLES));
  // A timed-out access returns zero, so an aborted fetch decodes as a NOP.
  assign rdata_v    = mem_ack ? mem_rdata : '0;

  always_comb begin
    state_d     = state_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    if_rdata_d  = if_rdata_q;
    dm_rdata_d  = dm_rdata_q;
    bus_err_d   = bus_err_q;
    d_done_d    = d_done_q;
    i_done_d    = i_done_q;
    to_cnt_d    = to_cnt_q;

    if (!pipe_stall) begin
      d_done_d = 1'b0;
      i_done_d = 1'b0;
    end

    case (state_q)
      IDLE: begin
        to_cnt_d = '0;
        if (dm_req && !d_done_q) begin
          state_d     = DATA;
          mem_req_d   = 1'b1;
          mem_we_d    = dm_write;
          mem_addr_d  = dm_addr & WORD_MASK;
          mem_wdata_d = dm_wdata;
          if (dm_addr[1:0] != 2'b00) bus_err_d = 1'b1;
        end else if (if_req && !i_done_q) begin
          state_d    = FETCH;
          mem_req_d  = 1'b1;
          mem_we_d   = 1'b0;
          mem_addr_d = if_addr & WORD_MASK;
        end else begin
          mem_req_d = 1'b0;
        end
      end
      DATA, FETCH: begin
        if (mem_ack || timeout) begin
          state_d   = IDLE;
          mem_req_d = 1'b0;
          to_cnt_d  = '0;
          if (!mem_ack) bus_err_d = 1'b1;
          if (state_q == DATA) begin
            d_done_d = 1'b1;
            if (!mem_we_q) dm_rdata_d = rdata_v;
          end else begin
            i_done_d   = 1'b1;
            if_rdata_d = rdata_v;
          end
        end else begin
          to_cnt_d = to_cnt_q + TO_WIDTH'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      if_rdata_q  <= '0;
      dm_rdata_q  <= '0;
      bus_err_q   <= 1'b0;
      d_done_q    <= 1'b0;
      i_done_q    <= 1'b0;
      to_cnt_q    <= '0;
    end else begin
      state_q     <= state_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      if_rdata_q  <= if_rdata_d;
      dm_rdata_q  <= dm_rdata_d;
      bus_err_q   <= bus_err_d;
      d_done_q    <= d_done_d;
      i_done_q    <= i_done_d;
      to_cnt_q    <= to_cnt_d;
    end
  end

  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign if_rdata  = if_rdata_q;
  assign dm_rdata  = dm_rdata_q;
  assign bus_err   = bus_err_q;

endmodule
